// File: rtl/compiler_pkg.sv
// Shared constants for the word parser / line dispatch / CPU path.
// FSM state encodings, line error codes and the opcode values exchanged between blocks.
package compiler_pkg;

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PARSE    = 2'd1,
        ERR_OVERFLOW = 2'd2
    } err_code_t;

    localparam logic [15:0] OPCODE_NOP  = 16'h0000;
    localparam logic [15:0] OPCODE_PUSH = 16'h0001;
    localparam logic [15:0] OPCODE_ADD  = 16'h0002;
    localparam logic [15:0] OPCODE_SUB  = 16'h0003;

endpackage

// File: rtl/line_fifo.sv
// Entry storage with three pointers: rd (CPU head), cm (commit boundary), wr (next write).
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module line_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     commit,
    input  logic                     rollback,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd;
    logic [PW-1:0]    cm;
    logic [PW-1:0]    wr;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd <= '0;
            cm <= '0;
            wr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr[AW-1:0]] <= wdata;
            end
            if (rollback) begin
                wr <= cm;
            end else if (push) begin
                wr <= wr + PW'(1);
            end
            // commit always accompanies the push of the line's last word
            if (commit) begin
                cm <= wr + PW'(1);
            end
            if (pop) begin
                rd <= rd + PW'(1);
            end
        end
    end

    assign rdata = mem[rd[AW-1:0]];
    assign full  = (wr - rd) == PW'(DEPTH);
    assign empty = (cm == rd);
    assign count = cm - rd;

endmodule

// File: rtl/line_dispatch.sv
// Line-atomic opcode buffer: parsed words are staged per line and released to the CPU
// only after the line's last word arrives cleanly; bad or oversized lines are dropped whole.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_ACCEPT  | staging words of the current line into the buffer
// ST_DISCARD | dropping the remaining words of a rejected line until eol
module line_dispatch
    import compiler_pkg::*;
#(
    parameter int DATA   = 32,
    parameter int OPCODE = 16,
    parameter int DEPTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [OPCODE-1:0]       i_opcode,
    input  logic [DATA-1:0]         i_data,
    input  logic                    i_err,
    input  logic                    i_eol,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [OPCODE-1:0]       o_opcode,
    output logic [DATA-1:0]         o_data,
    input  logic                    i_ack,
    output logic                    o_line_done,
    output logic                    o_err,
    output logic [1:0]              o_err_code,
    output logic [$clog2(DEPTH):0]  o_count
);
    state_t                    state;
    logic                      full;
    logic                      empty;
    logic                      accept;
    logic                      push;
    logic                      commit;
    logic                      parse_fail;
    logic                      overflow;
    logic                      rollback;
    logic                      pop;
    logic [OPCODE+DATA-1:0]    rdata;

    // Full with nothing committed can never drain, so the partial line is abandoned.
    assign overflow   = i_en && (state == ST_ACCEPT) && full && empty;
    assign o_ready    = i_en && ((state == ST_DISCARD) || !full);
    assign accept     = i_valid && o_ready;
    assign push       = accept && (state == ST_ACCEPT) && !i_err;
    assign commit     = push && i_eol;
    assign parse_fail = accept && (state == ST_ACCEPT) && i_err;
    assign rollback   = parse_fail || overflow;
    assign o_valid    = i_en && !empty;
    assign pop        = o_valid && i_ack;

    line_fifo #(
        .WIDTH (OPCODE + DATA),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (push),
        .wdata    ({i_opcode, i_data}),
        .pop      (pop),
        .commit   (commit),
        .rollback (rollback),
        .rdata    (rdata),
        .full     (full),
        .empty    (empty),
        .count    (o_count)
    );

    assign o_opcode = rdata[OPCODE+DATA-1:DATA];
    assign o_data   = rdata[DATA-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= ST_ACCEPT;
            o_line_done <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= ERR_NONE;
        end else begin
            o_line_done <= commit;
            o_err       <= rollback;
            if (i_en) begin
                case (state)
                    ST_ACCEPT: begin
                        if (overflow) begin
                            o_err_code <= ERR_OVERFLOW;
                            state      <= ST_DISCARD;
                        end else if (parse_fail) begin
                            o_err_code <= ERR_PARSE;
                            state      <= i_eol ? ST_ACCEPT : ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (accept && i_eol) begin
                            state <= ST_ACCEPT;
                        end
                    end
                    default: state <= ST_ACCEPT;
                endcase
            end
        end
    end

endmodule
